// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared definitions for the fetch-stage branch predictor.
//   kind_e          control-transfer class reported by ID (BR/JAL/JALR/RET)
//   ctr_weak_nt()   counter reset value (weakly not-taken) for a given width
//   ctr_weak_t()    counter value on BR allocation (weakly taken)
//   ctr_max()       upper saturation value of the direction counter
package bp_pkg;

   typedef enum logic [1:0] {
      KindBr   = 2'd0,
      KindJal  = 2'd1,
      KindJalr = 2'd2,
      KindRet  = 2'd3
   } kind_e;

   localparam int unsigned CtrBitsDefault = 2;

   function automatic int unsigned ctr_weak_nt(input int unsigned bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

   function automatic int unsigned ctr_weak_t(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

   function automatic int unsigned ctr_max(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: bundle between the pipeline (master) and the predictor (slave).
//   lookup_pc                 IF PC to predict
//   pred_taken, pred_target   combinational prediction for lookup_pc
//   upd_valid/pc/kind/taken/target   resolution feedback from ID
//   ras_push, ras_push_addr, ras_pop  return-stack maintenance from ID
//   ras_empty                 return stack holds no entries
interface branch_predictor_if
   import bp_pkg::*;
#(
   parameter int unsigned XLEN = 32
);

   logic [XLEN-1:0] lookup_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   kind_e           upd_kind;
   logic            upd_taken;
   logic [XLEN-1:0] upd_target;
   logic            ras_push;
   logic [XLEN-1:0] ras_push_addr;
   logic            ras_pop;
   logic            ras_empty;

   modport master (
      output lookup_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
      output ras_push, ras_push_addr, ras_pop,
      input  pred_taken, pred_target, ras_empty
   );

   modport slave (
      input  lookup_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
      input  ras_push, ras_push_addr, ras_pop,
      output pred_taken, pred_target, ras_empty
   );

endinterface

// File: rtl/branch_predictor_return_stack.sv
// return_stack: circular return-address stack.
//   clk, rst    clock, synchronous active-high reset
//   push        write push_addr as new top (overwrites oldest when full)
//   push_addr   return address to push
//   pop         drop top entry (ignored when empty)
//   top         current top entry
//   empty       no entries held
// push and pop together replace the top entry; on an empty stack this acts as a push.
module return_stack #(
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [XLEN-1:0] push_addr,
   input  logic            pop,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0]  stack_q [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic             full;

   always_comb begin
      ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
      full    = (cnt_q == CNT_W'(RAS_DEPTH));
      empty   = (cnt_q == '0);
      top     = stack_q[ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else if (push && pop && !empty) begin
         stack_q[ptr_q] <= push_addr;
      end else if (push) begin
         // When full the slot after top is the oldest entry, so it is overwritten.
         stack_q[ptr_inc] <= push_addr;
         ptr_q            <= ptr_inc;
         if (!full) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr_q <= ptr_dec;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating direction counters
// plus a return-address stack, looked up combinationally in IF and trained from ID.
//   clk, rst   clock, synchronous active-high reset
//   bus        branch_predictor_if.slave (lookup, prediction, update, RAS control)
// Lookups see pre-update contents; updates and RAS writes land on the rising edge.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned CTR_BITS  = CtrBitsDefault,
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned XLEN      = 32
) (
   input logic              clk,
   input logic              rst,
   branch_predictor_if.slave bus
);

   localparam int unsigned IDX   = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX - 2;

   localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(ctr_weak_t(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CtrMax    = CTR_BITS'(ctr_max(CTR_BITS));

   // BTB state as flop arrays so reset can clear every entry in one cycle.
   logic                valid_q  [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   kind_e               kind_q   [ENTRIES];
   logic [XLEN-1:0]     target_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

   logic [IDX-1:0]      lk_idx;
   logic [TAG_W-1:0]    lk_tag;
   logic                lk_hit;
   logic [IDX-1:0]      up_idx;
   logic [TAG_W-1:0]    up_tag;
   logic                up_hit;
   logic [CTR_BITS-1:0] ctr_next;
   logic                pred_taken;
   logic [XLEN-1:0]     pred_target;
   logic [XLEN-1:0]     ras_top;
   logic                ras_empty;
   logic                unused_pc_bits;

   // Instructions are word aligned; the low PC bits carry no information.
   assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

   return_stack #(
      .RAS_DEPTH (RAS_DEPTH),
      .XLEN      (XLEN)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.ras_push),
      .push_addr (bus.ras_push_addr),
      .pop       (bus.ras_pop),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   // Lookup
   always_comb begin
      lk_idx      = bus.lookup_pc[IDX+1:2];
      lk_tag      = bus.lookup_pc[XLEN-1:IDX+2];
      lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = 1'b0;
      pred_target = '0;
      if (lk_hit) begin
         unique case (kind_q[lk_idx])
            KindBr:  pred_taken = ctr_q[lk_idx][CTR_BITS-1];
            default: pred_taken = 1'b1;
         endcase
         if (kind_q[lk_idx] == KindRet && !ras_empty) begin
            pred_target = ras_top;
         end else begin
            pred_target = target_q[lk_idx];
         end
      end
   end

   assign bus.pred_taken  = pred_taken;
   assign bus.pred_target = pred_target;
   assign bus.ras_empty   = ras_empty;

   // Update-side decode and saturating counter step
   always_comb begin
      up_idx = bus.upd_pc[IDX+1:2];
      up_tag = bus.upd_pc[XLEN-1:IDX+2];
      up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      if (bus.upd_taken) begin
         ctr_next = (ctr_q[up_idx] == CtrMax) ? ctr_q[up_idx] : ctr_q[up_idx] + CTR_BITS'(1);
      end else begin
         ctr_next = (ctr_q[up_idx] == '0) ? ctr_q[up_idx] : ctr_q[up_idx] - CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CtrWeakNt;
         end
      end else if (bus.upd_valid) begin
         if (up_hit) begin
            if (bus.upd_kind == KindBr) begin
               ctr_q[up_idx] <= ctr_next;
               if (bus.upd_taken) begin
                  target_q[up_idx] <= bus.upd_target;
               end
            end else begin
               target_q[up_idx] <= bus.upd_target;
            end
         end else if (bus.upd_taken) begin
            // Allocate only on taken: a not-taken miss would predict fall-through anyway.
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            kind_q[up_idx]   <= bus.upd_kind;
            target_q[up_idx] <= bus.upd_target;
            if (bus.upd_kind == KindBr) begin
               ctr_q[up_idx] <= CtrWeakT;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
   import bp_pkg::*;

   localparam int unsigned ENTRIES   = 16;
   localparam int unsigned CTR_BITS  = 2;
   localparam int unsigned RAS_DEPTH = 4;
   localparam int unsigned XLEN      = 32;
   localparam int IDX  = $clog2(ENTRIES);
   localparam int CMAX = (1 << CTR_BITS) - 1;
   localparam int WT   = 1 << (CTR_BITS - 1);
   localparam int WNT  = WT - 1;

   logic clk;
   logic rst;

   branch_predictor_if #(.XLEN(XLEN)) bus ();

   branch_predictor #(
      .ENTRIES   (ENTRIES),
      .CTR_BITS  (CTR_BITS),
      .RAS_DEPTH (RAS_DEPTH),
      .XLEN      (XLEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Reference model: per-index entry records and a queue for the return stack.
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int          m_kind  [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_ras   [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
      int idx;
      int unsigned tg_bits;
      idx     = int'((pc >> 2) % ENTRIES);
      tg_bits = pc >> (IDX + 2);
      tk = 1'b0;
      tg = 32'h0;
      if (m_valid[idx] && m_tag[idx] == tg_bits) begin
         tk = (m_kind[idx] != 0) || (m_ctr[idx] >= WT);
         if (m_kind[idx] == 3 && m_ras.size() > 0) tg = m_ras[m_ras.size()-1];
         else tg = m_tgt[idx];
      end
   endtask

   task automatic model_clock();
      int idx;
      int unsigned tg_bits;
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = WNT;
         end
         m_ras.delete();
         return;
      end
      if (bus.upd_valid) begin
         idx     = int'((bus.upd_pc >> 2) % ENTRIES);
         tg_bits = bus.upd_pc >> (IDX + 2);
         if (m_valid[idx] && m_tag[idx] == tg_bits) begin
            if (bus.upd_kind == KindBr) begin
               if (bus.upd_taken) begin
                  if (m_ctr[idx] < CMAX) m_ctr[idx]++;
                  m_tgt[idx] = bus.upd_target;
               end else if (m_ctr[idx] > 0) begin
                  m_ctr[idx]--;
               end
            end else begin
               m_tgt[idx] = bus.upd_target;
            end
         end else if (bus.upd_taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg_bits;
            m_kind[idx]  = int'(bus.upd_kind);
            m_tgt[idx]   = bus.upd_target;
            if (bus.upd_kind == KindBr) m_ctr[idx] = WT;
         end
      end
      if (bus.ras_push && bus.ras_pop && m_ras.size() > 0) begin
         m_ras[m_ras.size()-1] = bus.ras_push_addr;
      end else if (bus.ras_push) begin
         m_ras.push_back(bus.ras_push_addr);
         if (m_ras.size() > int'(RAS_DEPTH)) void'(m_ras.pop_front());
      end else if (bus.ras_pop && m_ras.size() > 0) begin
         void'(m_ras.pop_back());
      end
   endtask

   task automatic check_pred(input string tag);
      logic        etk;
      logic [31:0] etg;
      model_lookup(bus.lookup_pc, etk, etg);
      check({tag, ".taken"}, {31'b0, bus.pred_taken}, {31'b0, etk});
      check({tag, ".target"}, bus.pred_target, etg);
      check({tag, ".empty"}, {31'b0, bus.ras_empty}, {31'b0, (m_ras.size() == 0)});
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
      rst           = 1'b0;
      bus.upd_valid = 1'b0;
      bus.ras_push  = 1'b0;
      bus.ras_pop   = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input kind_e k, input logic tk,
                      input logic [31:0] tgt);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_kind   = k;
      bus.upd_taken  = tk;
      bus.upd_target = tgt;
   endtask

   task automatic look(input logic [31:0] pc);
      bus.lookup_pc = pc;
      #1;
   endtask

   function automatic kind_e kind_of(input logic [31:0] pc);
      logic [31:0] k;
      k = (pc >> 2) + (pc >> 6);
      return kind_e'(k[1:0]);
   endfunction

   initial begin
      logic [31:0] ras_exp [4];
      logic [31:0] pc;
      rst               = 1'b1;
      bus.lookup_pc     = 32'h100;
      bus.upd_valid     = 1'b0;
      bus.upd_pc        = 32'h0;
      bus.upd_kind      = KindBr;
      bus.upd_taken     = 1'b0;
      bus.upd_target    = 32'h0;
      bus.ras_push      = 1'b0;
      bus.ras_push_addr = 32'h0;
      bus.ras_pop       = 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = WNT;
      end

      // Reset
      tick();
      look(32'h100);
      check("reset.taken", {31'b0, bus.pred_taken}, 32'd0);
      check("reset.target", bus.pred_target, 32'h0);
      check("reset.empty", {31'b0, bus.ras_empty}, 32'd1);

      // BR allocation and training
      upd(32'h100, KindBr, 1'b1, 32'h140);
      tick();
      look(32'h100);
      check("br_alloc.taken", {31'b0, bus.pred_taken}, 32'd1);
      check("br_alloc.target", bus.pred_target, 32'h140);
      repeat (2) begin
         upd(32'h100, KindBr, 1'b0, 32'h140);
         tick();
      end
      check("br_nt2.taken", {31'b0, bus.pred_taken}, 32'd0);
      check_pred("br_nt2");
      repeat (3) begin
         upd(32'h100, KindBr, 1'b1, 32'h140);
         tick();
      end
      check("br_t3.taken", {31'b0, bus.pred_taken}, 32'd1);
      upd(32'h100, KindBr, 1'b1, 32'h140);
      tick();
      upd(32'h100, KindBr, 1'b0, 32'h140);
      tick();
      // Saturated at 3, so one not-taken still predicts taken.
      check("br_sat.taken", {31'b0, bus.pred_taken}, 32'd1);
      upd(32'h100, KindBr, 1'b0, 32'h140);
      tick();
      check("br_sat2.taken", {31'b0, bus.pred_taken}, 32'd0);

      // Aliasing
      upd(32'h100 + 4 * ENTRIES, KindJal, 1'b1, 32'h200);
      tick();
      look(32'h100);
      check("alias.miss.taken", {31'b0, bus.pred_taken}, 32'd0);
      check("alias.miss.target", bus.pred_target, 32'h0);
      look(32'h100 + 4 * ENTRIES);
      check("alias.hit.taken", {31'b0, bus.pred_taken}, 32'd1);
      check("alias.hit.target", bus.pred_target, 32'h200);

      // Same-cycle update and lookup
      upd(32'h100, KindBr, 1'b1, 32'h140);
      tick();
      upd(32'h100, KindBr, 1'b1, 32'h180);
      look(32'h100);
      check("nobypass.old", bus.pred_target, 32'h140);
      tick();
      check("nobypass.new", bus.pred_target, 32'h180);

      // RAS overflow and underflow
      upd(32'h300, KindRet, 1'b1, 32'h3F0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         bus.ras_push      = 1'b1;
         bus.ras_push_addr = 32'(i * 16);
         tick();
      end
      ras_exp[0] = 32'h50;
      ras_exp[1] = 32'h40;
      ras_exp[2] = 32'h30;
      ras_exp[3] = 32'h20;
      look(32'h300);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ras_pop%0d.target", i), bus.pred_target, ras_exp[i]);
         check_pred($sformatf("ras_pop%0d", i));
         bus.ras_pop = 1'b1;
         tick();
      end
      check("ras_under.empty", {31'b0, bus.ras_empty}, 32'd1);
      bus.ras_pop = 1'b1;
      tick();
      check("ras_pop5.empty", {31'b0, bus.ras_empty}, 32'd1);
      check("ras_pop5.taken", {31'b0, bus.pred_taken}, 32'd1);
      check("ras_pop5.target", bus.pred_target, 32'h3F0);

      // Push+pop in one cycle
      bus.ras_push = 1'b1; bus.ras_pop = 1'b1; bus.ras_push_addr = 32'h55;
      tick();
      check("pp_empty.empty", {31'b0, bus.ras_empty}, 32'd0);
      check("pp_empty.target", bus.pred_target, 32'h55);
      bus.ras_pop = 1'b1;
      tick();
      bus.ras_push = 1'b1; bus.ras_push_addr = 32'h10;
      tick();
      bus.ras_push = 1'b1; bus.ras_push_addr = 32'h20;
      tick();
      bus.ras_push = 1'b1; bus.ras_pop = 1'b1; bus.ras_push_addr = 32'h99;
      tick();
      check("pp.top", bus.pred_target, 32'h99);
      bus.ras_pop = 1'b1;
      tick();
      check("pp.below", bus.pred_target, 32'h10);
      check("pp.empty", {31'b0, bus.ras_empty}, 32'd0);
      rst = 1'b1; bus.ras_push = 1'b1; bus.ras_push_addr = 32'h77;
      upd(32'h300, KindRet, 1'b1, 32'h3AA);
      tick();
      check("pp_rst.empty", {31'b0, bus.ras_empty}, 32'd1);
      check("pp_rst.taken", {31'b0, bus.pred_taken}, 32'd0);
      check_pred("pp_rst");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         pc = ($urandom_range(0, 2) << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2);
         bus.upd_valid = ($urandom_range(0, 3) != 0);
         upd(pc, kind_of(pc), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
         bus.upd_valid     = ($urandom_range(0, 3) != 0);
         bus.ras_push      = ($urandom_range(0, 2) == 0);
         bus.ras_pop       = ($urandom_range(0, 2) == 0);
         bus.ras_push_addr = $urandom & 32'hFFFF_FFFC;
         rst               = ($urandom_range(0, 63) == 0);
         pc = ($urandom_range(0, 2) << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2);
         look(pc);
         check_pred($sformatf("rand%0d", n));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage branch predictor for the 5-stage RV32I pipeline. A direct-mapped branch target buffer (BTB) with per-entry saturating direction counters sits beside the instruction memory in IF. A return-address stack (RAS) supplies targets for function returns. Resolution information comes back from ID, where branches and jumps are decided, and the existing PC-select and IF/ID-flush logic consumes the prediction.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB entries; must be a power of two, at least 2.
- `CTR_BITS`, 2: width of each direction counter.
- `RAS_DEPTH`, 4: number of return-stack entries; at least 1.
- `XLEN`, 32: PC and target width.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `lookup_pc`, input, XLEN: current IF PC.
- `pred_taken`, output, 1: predict redirect for `lookup_pc`.
- `pred_target`, output, XLEN: predicted next PC, valid when `pred_taken`=1.
- `upd_valid`, input, 1: ID resolved a control-transfer instruction this cycle.
- `upd_pc`, input, XLEN: PC of the resolved instruction.
- `upd_kind`, input, 2: instruction class, one of BR, JAL, JALR, RET.
- `upd_taken`, input, 1: actual direction.
- `upd_target`, input, XLEN: actual target.
- `ras_push`, input, 1: call resolved in ID (rd = x1 or x5).
- `ras_push_addr`, input, XLEN: return address, i.e. PC+4 of the call.
- `ras_pop`, input, 1: return resolved in ID.
- `ras_empty`, output, 1: RAS holds no entries.

## Operation
- Index = `lookup_pc[IDX+1:2]`, where IDX = log2(ENTRIES). Tag = `lookup_pc[XLEN-1:IDX+2]`.
- Each entry holds: valid, tag, kind, target and counter.
- Hit = valid AND tag match.
- `pred_taken` is set on a hit when any of these holds:
  - kind is JAL, JALR or RET;
  - kind is BR and the counter MSB is 1.
- `pred_target` selection:
  - kind RET with the RAS non-empty: RAS top;
  - otherwise: stored target;
  - on a miss: 0.
- Update, when `upd_valid`=1, on the entry indexed by `upd_pc`:
  - Tag match, BR: the counter increments on taken and decrements on not-taken, saturating at 0 and at 2^CTR_BITS−1. The target is rewritten when taken.
  - Tag match, other kinds: the target is rewritten.
  - Tag miss with `upd_taken`=1: allocate the entry, overwriting valid, tag, kind and target. A BR counter starts at weakly-taken (2^(CTR_BITS−1)).
  - Tag miss with `upd_taken`=0: no change.
- RAS is circular, with a top pointer and an occupancy count that saturates at RAS_DEPTH.
  - Push with the stack full overwrites the oldest entry.
  - Pop with the stack empty changes nothing.
  - Push and pop in the same cycle replace the top entry; the count is unchanged. If the stack is empty, it becomes one entry.
- `ras_empty` = (count == 0).

## Timing
- Lookup is combinational: `pred_*` follows `lookup_pc` in the same cycle.
- Update and RAS writes take effect on the rising `clk` edge and are visible to lookups from the next cycle.
- No bypass: a lookup and an update to the same index in the same cycle return the pre-update contents.
- `rst` acts on the rising edge:
  - all valid bits cleared;
  - counters set to weakly-not-taken (2^(CTR_BITS−1)−1);
  - RAS count and pointer set to 0.
- Values after reset: `pred_taken`=0, `pred_target`=0, `ras_empty`=1.
- `rst` asserted mid-update wins; the update is discarded.
- Update inputs are ignored while `upd_valid`=0. `ras_push` and `ras_pop` are independent of `upd_valid`.

## Structure
- Package `bp_pkg` holds:
  - the `upd_kind` encoding: BR=0, JAL=1, JALR=2, RET=3;
  - the counter init and saturation constants, derived from CTR_BITS.
- Sub-module `return_stack`, parameters RAS_DEPTH and XLEN, holds the pointer, count and storage.
- The BTB arrays (valid, tag, kind, target, counter) are flop arrays inside `branch_predictor`, not memory macros, so they can be cleared in one cycle on reset.

## Test plan
- **Reset:** assert `rst` 1 cycle, lookup 0x100 → `pred_taken`=0, `pred_target`=0, `ras_empty`=1.
- **BR allocation and training:**
  - Update BR at 0x100, taken, target 0x140 → next cycle, lookup 0x100 gives taken/0x140.
  - Two not-taken updates → `pred_taken`=0.
  - Three taken updates → `pred_taken`=1; a fourth taken update leaves the counter at 3.
- **Aliasing:** allocate 0x100 (→0x140), then taken JAL at 0x100+4·ENTRIES (→0x200) → lookup 0x100 misses (`pred_taken`=0), alias PC hits with 0x200.
- **Same-cycle update/lookup:** update 0x100 to target 0x180 while looking up 0x100 → that cycle shows the old target 0x140, the next cycle shows 0x180.
- **RAS overflow and underflow:**
  - Five pushes with RAS_DEPTH=4 (0x10, 0x20, 0x30, 0x40, 0x50), with a RET allocated at 0x300.
  - Pops return targets 0x50, 0x40, 0x30, 0x20; `ras_empty`=1 after the 4th pop.
  - A 5th pop changes nothing; a RET lookup then gives the stored BTB target.
- **Push+pop same cycle:** stack [0x10, 0x20], push 0x99 with pop → top=0x99, count=2; a reset mid-sequence gives `ras_empty`=1.
